// File: rtl/snn_core_param_if.sv
// Control, result and memory-port bundle for snn_core_param.
// master = host/memory side, slave = the inference core.
interface snn_core_param_if #(
  parameter int N_IN   = 784,
  parameter int N_HID  = 32,
  parameter int N_OUT  = 10,
  parameter int LUT_AW = 11
);
  logic                             start;
  logic                             abort;
  logic                             q_input;
  logic [$clog2(N_IN)-1:0]          addr_input_unit;
  logic [$clog2(N_IN*N_HID)-1:0]    hw_addr;
  logic [7:0]                       hw_q;
  logic [$clog2(N_HID*N_OUT)-1:0]   ow_addr;
  logic [7:0]                       ow_q;
  logic [LUT_AW-1:0]                lut_addr;
  logic [7:0]                       lut_q;
  logic                             busy;
  logic                             done;
  logic [$clog2(N_OUT)-1:0]         digit;
  logic [7:0]                       max_val;

  modport master (
    output start, abort, q_input, hw_q, ow_q, lut_q,
    input  addr_input_unit, hw_addr, ow_addr, lut_addr, busy, done, digit, max_val
  );

  modport slave (
    input  start, abort, q_input, hw_q, ow_q, lut_q,
    output addr_input_unit, hw_addr, ow_addr, lut_addr, busy, done, digit, max_val
  );
endinterface

// File: rtl/snn_core_param.sv
// Two-layer fully-connected inference core: one signed MAC shared by both layers,
// external weight/LUT ROMs, internal hidden registers and a running argmax.
module snn_core_param #(
  parameter int N_IN   = 784,
  parameter int N_HID  = 32,
  parameter int N_OUT  = 10,
  parameter int ACC_W  = 26,
  parameter int FRAC   = 7,
  parameter int LUT_AW = 11
) (
  input logic            clk,
  input logic            rst_n,
  snn_core_param_if.slave bus
);
  localparam int IW  = $clog2(N_IN);
  localparam int HCW = (N_HID > 1) ? $clog2(N_HID) : 1;
  localparam int OCW = $clog2(N_OUT);
  localparam int HWA = $clog2(N_IN * N_HID);
  localparam int OWA = $clog2(N_HID * N_OUT);
  localparam int CW  = ((ACC_W > LUT_AW) ? ACC_W : LUT_AW) + 1;
  localparam logic signed [CW-1:0]  LUT_MAX  = CW'(2 ** (LUT_AW - 1) - 1);
  localparam logic signed [CW-1:0]  LUT_MIN  = ~LUT_MAX;
  localparam logic [LUT_AW-1:0]     LUT_BIAS = {1'b1, {(LUT_AW-1){1'b0}}};

  typedef enum logic [3:0] {
    IDLE, HID_MAC, HID_DRAIN, HID_ACT, HID_WR,
    OUT_MAC, OUT_DRAIN, OUT_ACT, OUT_WR, DONE
  } state_t;

  state_t state, state_nx;

  logic [IW-1:0]            i_cnt;
  logic [HCW-1:0]           h_cnt;
  logic [HCW-1:0]           k_cnt;
  logic [OCW-1:0]           o_cnt;
  logic [HWA-1:0]           hw_cnt;
  logic [OWA-1:0]           ow_cnt;
  logic signed [ACC_W-1:0]  acc;
  logic                     acc_en;
  logic signed [7:0]        hid_op;
  logic [7:0]               hid_mem [2**HCW];
  logic [7:0]               best_val;
  logic [OCW-1:0]           best_idx;
  logic [OCW-1:0]           digit_r;
  logic [7:0]               max_r;

  logic                     last_i, last_h, last_k, last_o;
  logic                     issue, hid_layer, busy, done, take;
  logic signed [7:0]        op1, op2;
  logic signed [ACC_W-1:0]  prod;
  logic signed [CW-1:0]     s_full;
  logic [LUT_AW-1:0]        lut_addr;
  logic [OCW-1:0]           new_idx;
  logic [7:0]               new_val;

  assign last_i = (i_cnt == IW'(N_IN - 1));
  assign last_h = (h_cnt == HCW'(N_HID - 1));
  assign last_k = (k_cnt == HCW'(N_HID - 1));
  assign last_o = (o_cnt == OCW'(N_OUT - 1));

  always_comb begin
    state_nx = state;
    busy     = (state != IDLE);
    done     = (state == DONE);
    if (state != IDLE && bus.abort) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:      if (bus.start) state_nx = HID_MAC;
        HID_MAC:   if (last_i) state_nx = HID_DRAIN;
        HID_DRAIN: state_nx = HID_ACT;
        HID_ACT:   state_nx = HID_WR;
        HID_WR:    state_nx = last_h ? OUT_MAC : HID_MAC;
        OUT_MAC:   if (last_k) state_nx = OUT_DRAIN;
        OUT_DRAIN: state_nx = OUT_ACT;
        OUT_ACT:   state_nx = OUT_WR;
        OUT_WR:    state_nx = last_o ? DONE : OUT_MAC;
        DONE:      state_nx = IDLE;
        default:   state_nx = IDLE;
      endcase
    end
  end

  // Operands are selected by the layer the pipeline is currently in; the product
  // is formed at ACC_W width so narrow accumulators wrap exactly modulo 2^ACC_W.
  always_comb begin
    issue     = (state == HID_MAC) || (state == OUT_MAC);
    hid_layer = (state == HID_MAC) || (state == HID_DRAIN);
    op1       = hid_layer ? (bus.q_input ? 8'sd127 : 8'sd0) : hid_op;
    op2       = hid_layer ? bus.hw_q : bus.ow_q;
    prod      = ACC_W'(op1) * ACC_W'(op2);
  end

  always_comb begin
    s_full = CW'(acc >>> FRAC);
    if (!busy)                 lut_addr = '0;
    else if (s_full > LUT_MAX) lut_addr = '1;
    else if (s_full < LUT_MIN) lut_addr = '0;
    else                       lut_addr = s_full[LUT_AW-1:0] ^ LUT_BIAS;
  end

  always_comb begin
    take    = (o_cnt == '0) || (bus.lut_q > best_val);
    new_idx = take ? o_cnt : best_idx;
    new_val = take ? bus.lut_q : best_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      i_cnt    <= '0;
      h_cnt    <= '0;
      k_cnt    <= '0;
      o_cnt    <= '0;
      hw_cnt   <= '0;
      ow_cnt   <= '0;
      acc      <= '0;
      acc_en   <= 1'b0;
      hid_op   <= '0;
      best_val <= '0;
      best_idx <= '0;
      digit_r  <= '0;
      max_r    <= '0;
    end else begin
      state  <= state_nx;
      acc_en <= issue && !bus.abort;
      if (state == IDLE || state == HID_WR || state == OUT_WR) acc <= '0;
      else if (acc_en)                                         acc <= acc + prod;
      case (state)
        IDLE: if (bus.start) begin
          i_cnt  <= '0;
          h_cnt  <= '0;
          k_cnt  <= '0;
          o_cnt  <= '0;
          hw_cnt <= '0;
          ow_cnt <= '0;
        end
        HID_MAC: begin
          hw_cnt <= hw_cnt + HWA'(1);
          i_cnt  <= last_i ? '0 : i_cnt + IW'(1);
        end
        HID_WR: h_cnt <= last_h ? '0 : h_cnt + HCW'(1);
        OUT_MAC: begin
          ow_cnt <= ow_cnt + OWA'(1);
          k_cnt  <= last_k ? '0 : k_cnt + HCW'(1);
          hid_op <= hid_mem[k_cnt];
        end
        OUT_WR: begin
          o_cnt    <= last_o ? '0 : o_cnt + OCW'(1);
          best_val <= new_val;
          best_idx <= new_idx;
          // Result is published on the edge entering DONE so it appears with done.
          if (last_o && !bus.abort) begin
            digit_r <= new_idx;
            max_r   <= new_val;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == HID_WR) hid_mem[h_cnt] <= bus.lut_q;
  end

  assign bus.addr_input_unit = i_cnt;
  assign bus.hw_addr         = hw_cnt;
  assign bus.ow_addr         = ow_cnt;
  assign bus.lut_addr        = lut_addr;
  assign bus.busy            = busy;
  assign bus.done            = done;
  assign bus.digit           = digit_r;
  assign bus.max_val         = max_r;
endmodule
